// File: rtl/prog_truth_table_unit_if.sv
// Handshake, result and table-load signals of prog_truth_table_unit.
// LUT_PARITY_EN adds the out_err result flag.
interface prog_truth_table_unit_if #(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned OUT_W = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_data;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             cfg_start;
   logic             cfg_valid;
   logic [OUT_W-1:0] cfg_data;
   logic             cfg_busy;
   logic             cfg_done;
`ifdef LUT_PARITY_EN
   logic             out_err;

   modport master (
      output in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_data,
      input  in_ready, out_valid, out_data, cfg_busy, cfg_done, out_err
   );
   modport slave (
      input  in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_data,
      output in_ready, out_valid, out_data, cfg_busy, cfg_done, out_err
   );
`else
   modport master (
      output in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_data,
      input  in_ready, out_valid, out_data, cfg_busy, cfg_done
   );
   modport slave (
      input  in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_data,
      output in_ready, out_valid, out_data, cfg_busy, cfg_done
   );
`endif
endinterface

// File: rtl/prog_truth_table_unit.sv
// Loadable 2**IN_W x OUT_W truth table with a registered valid/ready lookup path.
// Optional LUT_PARITY_EN stores an even-parity bit per entry and flags mismatches on out_err.
module prog_truth_table_unit #(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned OUT_W = 3
) (
   input logic clk,
   input logic rst_n,
   prog_truth_table_unit_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** IN_W;

   typedef enum logic [0:0] {StRun, StLoad} state_t;

   state_t           state_q, state_d;
   logic [IN_W-1:0]  ptr_q, ptr_d;
   logic             done_q, done_d;
   logic             tbl_we;
   logic [OUT_W-1:0] table_q [DEPTH];
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             accept;

   // Load sequencer: a restart takes priority over a write in the same cycle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      tbl_we  = 1'b0;
      unique case (state_q)
         StRun: begin
            if (bus.cfg_start) begin
               state_d = StLoad;
               ptr_d   = '0;
            end
         end
         StLoad: begin
            if (bus.cfg_start) begin
               ptr_d = '0;
            end else if (bus.cfg_valid) begin
               tbl_we = 1'b1;
               if (&ptr_q) begin
                  state_d = StRun;
                  ptr_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_comb begin
      bus.in_ready = (state_q == StRun) && (!out_valid_q || bus.out_ready);
      accept       = bus.in_valid && bus.in_ready;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = table_q[bus.in_data];
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         ptr_q       <= '0;
         done_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         done_q      <= done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      end else if (tbl_we) begin
         table_q[ptr_q] <= bus.cfg_data;
      end
   end

`ifdef LUT_PARITY_EN
   logic parity_q [DEPTH];
   logic out_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) parity_q[i] <= 1'b0;
         out_err_q <= 1'b0;
      end else begin
         if (tbl_we) parity_q[ptr_q] <= ^bus.cfg_data;
         if (accept) out_err_q <= parity_q[bus.in_data] ^ (^table_q[bus.in_data]);
      end
   end

   assign bus.out_err = out_err_q;
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.cfg_busy  = (state_q == StLoad);
   assign bus.cfg_done  = done_q;
endmodule
